// File: rtl/psychic5_frame_crc.sv
// ============================================================================
// psychic5_frame_crc
// ----------------------------------------------------------------------------
// Frame-signature monitor for the video output. On every pixel-clock-enable
// inside the active window the pixel is folded into a CRC-32 and counted.
// When the last active pixel of a frame is sampled, the CRC, the pixel count
// and the frame counter are published together with a one-MCLK strobe.
//
// CRC: polynomial 0x04C11DB7, MSB-first, non-reflected, init 0xFFFFFFFF,
// no final XOR; all PX_W pixel bits are consumed in a single cycle.
//
// Optional build macro: PSYCHIC5_FRAME_CRC_GOLDEN_EN
//   Adds a golden-CRC comparator (i_GOLDEN_CRC, o_MISMATCH, o_MISMATCH_CNT).
//   Without it those ports and the comparator do not exist.
//
// Ports:
//   i_EMU_MCLK       master clock
//   i_EMU_INITRST_n  asynchronous active-low reset (synchronous release)
//   i_EMU_PXCEN_n    pixel clock enable, active-low
//   i_HCOUNTER       horizontal position
//   i_VCOUNTER       vertical position
//   i_VIDEODATA      pixel data, channel 0 in the MSBs
//   i_CAPTURE_EN     arms capture (level)
//   i_GOLDEN_CRC     expected frame CRC            (golden build only)
//   o_FRAME_CRC      CRC of the last completed frame
//   o_PIXEL_CNT      active pixels in the last completed frame (saturating)
//   o_FRAME_CNT      completed frames since reset (wraps)
//   o_FRAME_VALID    one-MCLK strobe when the three outputs above update
//   o_BUSY           high while a frame is being accumulated
//   o_MISMATCH       sticky golden mismatch flag   (golden build only)
//   o_MISMATCH_CNT   saturating mismatch count     (golden build only)
//
// Limitation: a single-pixel window (START == END on both axes) is not
// supported; the first pixel arms capture and the frame only closes on the
// following frame's sample.
// ============================================================================
module psychic5_frame_crc #(
    parameter int HCNT_W      = 9,
    parameter int VCNT_W      = 9,
    parameter int CH_NUM      = 3,
    parameter int CH_W        = 4,
    parameter int H_ACT_START = 128,
    parameter int H_ACT_END   = 383,
    parameter int V_ACT_START = 16,
    parameter int V_ACT_END   = 239
) (
    input  logic                     i_EMU_MCLK,
    input  logic                     i_EMU_INITRST_n,
    input  logic                     i_EMU_PXCEN_n,
    input  logic [HCNT_W-1:0]        i_HCOUNTER,
    input  logic [VCNT_W-1:0]        i_VCOUNTER,
    input  logic [CH_NUM*CH_W-1:0]   i_VIDEODATA,
    input  logic                     i_CAPTURE_EN,
`ifdef PSYCHIC5_FRAME_CRC_GOLDEN_EN
    input  logic [31:0]              i_GOLDEN_CRC,
    output logic                     o_MISMATCH,
    output logic [15:0]              o_MISMATCH_CNT,
`endif
    output logic [31:0]              o_FRAME_CRC,
    output logic [19:0]              o_PIXEL_CNT,
    output logic [15:0]              o_FRAME_CNT,
    output logic                     o_FRAME_VALID,
    output logic                     o_BUSY
);

    localparam int          PX_W     = CH_NUM * CH_W;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    state_t      state;
    logic [31:0] crc;
    logic [19:0] pix_cnt;

    // ------------------------------------------------------------------
    // Window decode
    // ------------------------------------------------------------------
    logic sample;
    logic active;
    logic first;
    logic last;

    assign sample = ~i_EMU_PXCEN_n;
    assign active = (i_HCOUNTER >= HCNT_W'(H_ACT_START)) &&
                    (i_HCOUNTER <= HCNT_W'(H_ACT_END))   &&
                    (i_VCOUNTER >= VCNT_W'(V_ACT_START)) &&
                    (i_VCOUNTER <= VCNT_W'(V_ACT_END));
    assign first  = sample && (i_HCOUNTER == HCNT_W'(H_ACT_START)) &&
                              (i_VCOUNTER == VCNT_W'(V_ACT_START));
    assign last   = sample && (i_HCOUNTER == HCNT_W'(H_ACT_END)) &&
                              (i_VCOUNTER == VCNT_W'(V_ACT_END));

    // ------------------------------------------------------------------
    // CRC datapath: one PX_W-bit step per sampled pixel
    // ------------------------------------------------------------------
    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [PX_W-1:0] d);
        logic [31:0] r;
        // NOTE: blocking assignments are correct here; r is a combinational
        // temporary that each loop iteration must see updated immediately.
        r = c;
        for (int i = PX_W - 1; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // The first pixel of a frame is seeded from CRC_INIT rather than from
    // whatever the register holds, so one step function serves both cases.
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic [19:0] pix_inc;

    assign crc_base = (state == ST_IDLE) ? CRC_INIT : crc;
    assign crc_next = crc_step(crc_base, i_VIDEODATA);
    assign pix_inc  = (pix_cnt == '1) ? pix_cnt : pix_cnt + 20'd1;

    // ------------------------------------------------------------------
    // Capture FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            state         <= ST_IDLE;
            crc           <= CRC_INIT;
            pix_cnt       <= '0;
            o_FRAME_CRC   <= '0;
            o_PIXEL_CNT   <= '0;
            o_FRAME_CNT   <= '0;
            o_FRAME_VALID <= 1'b0;
            o_BUSY        <= 1'b0;
        end else begin
            o_FRAME_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Arming mid-frame waits here until the next frame start.
                    if (first && i_CAPTURE_EN) begin
                        crc     <= crc_next;
                        pix_cnt <= 20'd1;
                        o_BUSY  <= 1'b1;
                        state   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!i_CAPTURE_EN) begin
                        // Abort: previous frame's results stay published.
                        o_BUSY <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (sample && active) begin
                        crc     <= crc_next;
                        pix_cnt <= pix_inc;
                        if (last) begin
                            o_FRAME_CRC   <= crc_next;
                            o_PIXEL_CNT   <= pix_inc;
                            o_FRAME_CNT   <= o_FRAME_CNT + 16'd1;
                            o_FRAME_VALID <= 1'b1;
                            o_BUSY        <= 1'b0;
                            state         <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // A frame start right after the last pixel is impossible
                    // at legal video timings, so nothing is watched here.
                    state <= ST_IDLE;
                end
                default: begin
                    o_BUSY <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PSYCHIC5_FRAME_CRC_GOLDEN_EN
    // ------------------------------------------------------------------
    // Golden comparator: evaluated on the strobe cycle, when o_FRAME_CRC
    // already carries the freshly completed frame's signature.
    // ------------------------------------------------------------------
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            o_MISMATCH     <= 1'b0;
            o_MISMATCH_CNT <= '0;
        end else if (o_FRAME_VALID && (o_FRAME_CRC != i_GOLDEN_CRC)) begin
            o_MISMATCH <= 1'b1;
            if (o_MISMATCH_CNT != '1) o_MISMATCH_CNT <= o_MISMATCH_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: doc/psychic5_frame_crc.md
Name: psychic5_frame_crc

Overview:
- Parametrised frame-signature monitor for the video output.
- Samples the pixel stream (counters plus RGB) on each pixel clock enable inside a configurable active window.
- Accumulates a CRC-32 and an active-pixel count per frame; reports both once per completed frame.
- Synthesisable successor to the simulation-only screen dump. Used for self-checking regressions and for on-target debug through an optional golden comparator.

Parameters:
- HCNT_W, 9, horizontal counter width
- VCNT_W, 9, vertical counter width
- CH_NUM, 3, colour channels per pixel
- CH_W, 4, bits per channel; pixel width PX_W = CH_NUM*CH_W
- H_ACT_START, 128, first active hcounter value
- H_ACT_END, 383, last active hcounter value
- V_ACT_START, 16, first active vcounter value
- V_ACT_END, 239, last active vcounter value

Ports:
- i_EMU_MCLK  in  1  master clock
- i_EMU_INITRST_n  in  1  asynchronous active-low reset
- i_EMU_PXCEN_n  in  1  pixel clock enable, active-low; the stream is sampled only on MCLK edges where this is low
- i_HCOUNTER  in  HCNT_W  horizontal position
- i_VCOUNTER  in  VCNT_W  vertical position
- i_VIDEODATA  in  PX_W  pixel data, channel 0 in the MSBs
- i_CAPTURE_EN  in  1  arms capture; level-sensitive
- o_FRAME_CRC  out  32  CRC of the last completed frame
- o_PIXEL_CNT  out  20  active pixels counted in the last completed frame
- o_FRAME_CNT  out  16  completed frames since reset; wraps
- o_FRAME_VALID  out  1  one-MCLK pulse when the three outputs above update
- o_BUSY  out  1  high while in state ACCUM

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; crc = 0xFFFFFFFF; internal pixel counter 0.
- sample = ~i_EMU_PXCEN_n.
- active = H_ACT_START<=h<=H_ACT_END and V_ACT_START<=v<=V_ACT_END.
- first = sample & h==H_ACT_START & v==V_ACT_START.
- last = sample & h==H_ACT_END & v==V_ACT_END.
- CRC definition:
  - polynomial 0x04C11DB7, MSB-first, non-reflected, no final XOR;
  - PX_W bits shifted per pixel within one cycle;
  - crc_next = F(crc, i_VIDEODATA).
- FSM IDLE:
  - o_BUSY=0;
  - on first & i_CAPTURE_EN: crc <= F(0xFFFFFFFF, data), pixel counter <= 1, go to ACCUM;
  - pixels before first are ignored (mid-frame arming waits for the next frame).
- FSM ACCUM:
  - on sample & active: crc <= crc_next, pixel counter +1;
  - on last (also active): latch o_FRAME_CRC <= crc_next and o_PIXEL_CNT <= counter+1 on the same edge; o_FRAME_VALID=1 for exactly that following cycle; o_FRAME_CNT+1; go to DONE;
  - samples outside the window are ignored.
- FSM DONE:
  - one cycle, then IDLE;
  - a first on the cycle immediately after last is not possible at legal timings and is ignored.
- Abort: i_CAPTURE_EN low in ACCUM returns to IDLE next edge with no pulse; outputs keep the previous frame's values.
- Single-pixel window (START==END both axes): first and last coincide; IDLE takes priority, entering ACCUM. The frame then completes on the next frame's sample, so single-pixel windows are unsupported (documented limitation).
- Pixel counter saturates at 2^20-1; o_FRAME_CNT wraps 0xFFFF->0.
- Reset mid-frame: everything clears immediately; the next capture starts at the next first.

Optional Feature:
PSYCHIC5_FRAME_CRC_GOLDEN_EN
- Defined:
  - adds input i_GOLDEN_CRC (32) and outputs o_MISMATCH (1, sticky) and o_MISMATCH_CNT (16, saturating);
  - on each o_FRAME_VALID cycle, if o_FRAME_CRC != i_GOLDEN_CRC then o_MISMATCH<=1 and o_MISMATCH_CNT+1;
  - both cleared only by reset.
- Undefined: these ports do not exist; no comparator logic.

Test Plan:
- Defaults; PXCEN low every 2nd MCLK; 384x264 counter sweep; constant data 0x000; CAPTURE_EN=1 -> o_FRAME_VALID pulses once per frame; o_PIXEL_CNT=57344; o_FRAME_CNT 1,2,3; o_FRAME_CRC identical across frames and equal to the C reference model.
- Same stream with one pixel at (200,100) changed 0x000->0xFFF in frame 2 only -> frame 2 CRC differs from frames 1 and 3; frames 1 and 3 match each other.
- CAPTURE_EN raised at v=50 -> no pulse that frame; first pulse at the end of the next frame with o_PIXEL_CNT=57344.
- CAPTURE_EN dropped at v=120 -> o_BUSY falls next cycle; no pulse; o_FRAME_CNT unchanged.
- Reset asserted mid-ACCUM asynchronously (between MCLK edges) -> all outputs 0 immediately; after release, the first pulse comes from the first full frame.
- GOLDEN_EN: i_GOLDEN_CRC = frame-1 CRC; inject a pixel error in frame 3 -> o_MISMATCH set after the frame-3 pulse; o_MISMATCH_CNT=1; stays set through frame 4.
